mux_nway_pipe: RTL
==================

// Module: mux_nway_pipe
// PURPOSE
//  Parametrised N-way operand select with one registered output stage and valid/ready handshake.
//  Successor to the fixed 3-input 16-bit combinational operand mux in the CPU core.
//  Sits between operand sources (regfile, EX/MEM forwarding, immediate) and the ALU input latch.
//  Out-of-range selects produce zero, raise a per-beat error flag and bump a saturating error counter.
// PARAMETERS
//  WIDTH       16  data width per input and output
//  NUM_INPUTS  3   number of data inputs, 2..16
//  SEL_W       3   select width; must satisfy 2**SEL_W >= NUM_INPUTS
//  CNT_W       8   error counter width
// PORTS
//  clk          in   1                 system clock, rising edge
//  rst_n        in   1                 asynchronous active-low reset
//  in_valid     in   1                 upstream beat valid
//  in_ready     out  1                 block can accept a beat this cycle
//  select       in   SEL_W             input index, sampled with the beat
//  data_in      in   NUM_INPUTS*WIDTH  flattened inputs; input k = data_in[k*WIDTH +: WIDTH]
//  out_valid    out  1                 output beat valid
//  out_ready    in   1                 downstream accepts beat
//  out_data     out  WIDTH             selected data
//  out_sel_err  out  1                 beat was produced from an out-of-range select
//  err_clr      in   1                 synchronous clear of err_count
//  err_count    out  CNT_W             saturating count of accepted out-of-range beats
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid=0, out_data=0, out_sel_err=0, err_count=0, skid empty.
//  - Accept = in_valid & in_ready. On accept: data = data_in[select] if select<NUM_INPUTS, else 0;
//    sel_err = (select>=NUM_INPUTS). Latency exactly 1 cycle from accept to out_valid.
//  - Output beat transfers when out_valid & out_ready. While out_valid=1 & out_ready=0,
//    out_data/out_sel_err hold stable; out_valid never drops without a transfer.
//  - Throughput 1 beat/cycle when out_ready held high.
//  - err_count: +1 per accepted beat with sel_err, saturates at 2**CNT_W-1 (no wrap).
//    err_clr has priority: same-cycle clear and error beat -> err_count=0.
//  - Inputs not sampled when in_valid=0; select/data_in are don't-care then.
//  - Reset mid-transfer discards any held beat; no output beat after reset until a new accept.
// CONFIGURATION
//  MUX_NWAY_SKID_EN defined:
//   - 2-entry skid: main output reg + skid reg. in_ready is a register output = !skid_valid.
//   - Beat accepted while the output stalls goes to skid; skid drains to the output reg on the next
//     transfer. Order preserved. No combinational path out_ready->in_ready.
//  MUX_NWAY_SKID_EN undefined:
//   - Single output reg. in_ready = !out_valid | out_ready (combinational).
//   - Simultaneous output transfer and accept replaces the register contents in the same cycle.
// STRUCTURE
//  - Package mux_pkg: default localparams (MUX_WIDTH=16, MUX_SEL_W=3), typedef
//    mux_beat_t {logic [WIDTH-1:0] data; logic sel_err;}, function in_range(sel, n).
//  - Sub-module mux_skid_buf (one beat of mux_beat_t, valid/ready both sides),
//    instantiated only under MUX_NWAY_SKID_EN.
//  - Elaboration assertions: NUM_INPUTS in 2..16, 2**SEL_W >= NUM_INPUTS.
// TESTING
//  1 Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid=0, err_count=0 same cycle (async).
//  2 Select sweep, NUM_INPUTS=3, inputs 16'h1111/2222/3333, out_ready=1: sel 0,1,2 -> out 1111,2222,3333
//    one cycle later, out_sel_err=0.
//  3 Out-of-range: sel=3'b101 -> out_data=0, out_sel_err=1, err_count 0->1; 300 bad beats with
//    CNT_W=8 -> err_count=255; err_clr with bad beat same cycle -> 0.
//  4 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> out_data stable, no beat lost or
//    duplicated. Scoreboard order check; without skid in_ready=0, with skid exactly one extra
//    beat accepted.
//  5 Streaming: in_valid=1, out_ready=1 for 100 beats random selects -> 100 outputs in order,
//    one per cycle.
//  6 Random in_valid/out_ready toggling, 10k beats, both macro settings: scoreboard match and
//    out_valid stable-until-transfer assertion.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared defaults, beat type and select range helper for mux_nway_pipe
package mux_pkg;
    localparam int MUX_WIDTH = 16;
    localparam int MUX_SEL_W = 3;

    typedef struct packed {
        logic [MUX_WIDTH-1:0] data;
        logic                 sel_err;
    } mux_beat_t;

    function automatic logic in_range(input int unsigned sel, input int unsigned n);
        return sel < n;
    endfunction
endpackage

// File: rtl/mux_skid_buf.sv
// rtl/mux_skid_buf.sv - output register plus one skid register; o_s_tready is a flop output
module mux_skid_buf import mux_pkg::*; #(
    parameter type T = mux_beat_t
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_s_tvalid,
    output logic o_s_tready,
    input  T     i_s_tdata,
    output logic o_m_tvalid,
    input  logic i_m_tready,
    output T     o_m_tdata
);
    logic r_main_valid;
    logic r_skid_valid;
    T     r_main;
    T     r_skid;
    logic w_accept;
    logic w_main_free;

    assign w_accept    = i_s_tvalid & ~r_skid_valid;
    assign w_main_free = ~r_main_valid | i_m_tready;

    // Skid only fills while the output stalls; it always drains before new input is taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_main       <= i_s_tdata;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid       <= i_s_tdata;
            r_skid_valid <= 1'b1;
        end
    end

    assign o_s_tready = ~r_skid_valid;
    assign o_m_tvalid = r_main_valid;
    assign o_m_tdata  = r_main;
endmodule

// File: rtl/mux_nway_pipe.sv
// rtl/mux_nway_pipe.sv - N-way registered operand select with valid/ready and error count
// Optional 2-entry skid output stage enabled by defining MUX_NWAY_SKID_EN.
module mux_nway_pipe import mux_pkg::*; #(
    parameter int WIDTH      = MUX_WIDTH,
    parameter int NUM_INPUTS = 3,
    parameter int SEL_W      = MUX_SEL_W,
    parameter int CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SEL_W-1:0]            select,
    input  logic [NUM_INPUTS*WIDTH-1:0] data_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_sel_err,
    input  logic                        err_clr,
    output logic [CNT_W-1:0]            err_count
);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sel_err;
    } beat_t;

    if (NUM_INPUTS < 2 || NUM_INPUTS > 16) begin : g_chk_num_inputs
        $error("mux_nway_pipe: NUM_INPUTS must be in 2..16");
    end
    if ((1 << SEL_W) < NUM_INPUTS) begin : g_chk_sel_w
        $error("mux_nway_pipe: SEL_W too narrow for NUM_INPUTS");
    end

    beat_t            w_beat;
    beat_t            w_out;
    logic             w_accept;
    logic [CNT_W-1:0] r_err_count;

    // Out-of-range selects leave data at zero.
    always_comb begin
        w_beat         = '0;
        w_beat.sel_err = ~in_range(32'(select), NUM_INPUTS);
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (32'(select) == k) w_beat.data = data_in[k*WIDTH +: WIDTH];
        end
    end

    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (w_accept && w_beat.sel_err && r_err_count != '1) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

`ifdef MUX_NWAY_SKID_EN
    mux_skid_buf #(.T(beat_t)) u_skid (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_s_tvalid (in_valid),
        .o_s_tready (in_ready),
        .i_s_tdata  (w_beat),
        .o_m_tvalid (out_valid),
        .i_m_tready (out_ready),
        .o_m_tdata  (w_out)
    );
`else
    logic  r_out_valid;
    beat_t r_out;

    assign in_ready = ~r_out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_beat;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign w_out     = r_out;
`endif

    assign out_data    = w_out.data;
    assign out_sel_err = w_out.sel_err;
    assign err_count   = r_err_count;
endmodule
